// File: rtl/range_lfsr_rng.sv
// rtl/range_lfsr_rng.sv - seedable Galois-LFSR random source with range-limited output (optional macro RNG_NO_REPEAT_EN)
module range_lfsr_rng #(
    parameter int          WIDTH      = 4,
    parameter int          LFSR_WIDTH = 16,
    parameter logic [31:0] SEED       = 32'h0000_ACE1,
    parameter int          MAX_TRIES  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_request,
    input  logic [WIDTH-1:0]      i_max,
    input  logic                  i_seed_load,
    input  logic [LFSR_WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0]      o_value,
    output logic                  o_valid,
    output logic                  o_busy
);

    // Right-shift Galois tap masks for the supported maximal-length polynomials.
    localparam logic [31:0] TAPS32 = (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
                                     (LFSR_WIDTH == 24) ? 32'h00E1_0000 :
                                     (LFSR_WIDTH == 32) ? 32'h8020_0003 :
                                                          32'h0000_B400;
    localparam logic [LFSR_WIDTH-1:0] TAPS   = TAPS32[LFSR_WIDTH-1:0];
    localparam logic [LFSR_WIDTH-1:0] SEED_L = SEED[LFSR_WIDTH-1:0];
    localparam int                    TRIES_W  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRIES_W-1:0]    LAST_TRY = TRIES_W'(MAX_TRIES - 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_next;
    logic [WIDTH-1:0]        max_q, mask, cand, fallback_base, fallback, deliver_value;
    logic [TRIES_W-1:0]      tries_q;
    logic                    out_of_range, accept, deliver, start, bump;

    assign o_busy = (state_q == DRAW);

    // One Galois step: shift right, fold the taps in when a one falls out.
    always_comb begin
        lfsr_next = {1'b0, lfsr_q[LFSR_WIDTH-1:1]};
        if (lfsr_q[0]) begin
            lfsr_next = lfsr_next ^ TAPS;
        end
    end

    // Smear max_q downward so the mask covers every bit up to its MSB.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask = mask | (max_q >> i);
        end
    end

    assign cand          = lfsr_q[WIDTH-1:0] & mask;
    assign out_of_range  = (cand > max_q);
    assign fallback_base = out_of_range ? (cand - max_q - WIDTH'(1)) : cand;

`ifdef RNG_NO_REPEAT_EN
    logic have_prev_q;
    logic repeat_rule;

    assign repeat_rule = have_prev_q && (max_q != '0);
    assign accept      = !out_of_range && !(repeat_rule && (cand == o_value));
    assign fallback    = (repeat_rule && (fallback_base == o_value)) ?
                         ((fallback_base == max_q) ? '0 : fallback_base + WIDTH'(1)) :
                         fallback_base;

    // Remembers whether o_value holds a real delivered value yet.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            have_prev_q <= 1'b0;
        end else if (deliver) begin
            have_prev_q <= 1'b1;
        end
    end
`else
    assign accept   = !out_of_range;
    assign fallback = fallback_base;
`endif

    // Next-state and handshake decisions for the draw FSM.
    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        bump          = 1'b0;
        deliver       = 1'b0;
        deliver_value = cand;
        case (state_q)
            IDLE: begin
                if (i_request) begin
                    start   = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (accept) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end else if (tries_q == LAST_TRY) begin
                    deliver       = 1'b1;
                    deliver_value = fallback;
                    state_d       = IDLE;
                end else begin
                    bump = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // LFSR free-runs every cycle so request timing feeds entropy; seed load wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr_q <= SEED_L;
        end else if (i_seed_load) begin
            lfsr_q <= (i_seed == '0) ? SEED_L : i_seed;
        end else begin
            lfsr_q <= lfsr_next;
        end
    end

    // Latched bound, retry counter and delivered value with its one-cycle strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            max_q   <= '0;
            tries_q <= '0;
            o_value <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= deliver;
            if (start) begin
                max_q   <= i_max;
                tries_q <= '0;
            end else if (bump) begin
                tries_q <= tries_q + TRIES_W'(1);
            end
            if (deliver) begin
                o_value <= deliver_value;
            end
        end
    end

endmodule

// File: tb/tb_range_lfsr_rng.sv
// tb/tb_range_lfsr_rng.sv - self-checking bench for range_lfsr_rng
module tb_range_lfsr_rng;

    localparam int          WIDTH = 4;
    localparam int          LW    = 16;
    localparam int          MT    = 8;
    localparam int unsigned TAPS  = 32'h0000_B400;
    localparam int unsigned SEED  = 32'h0000_ACE1;
`ifdef RNG_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             req;
    logic [WIDTH-1:0] max_in;
    logic             seed_load;
    logic [LW-1:0]    seed;
    logic [WIDTH-1:0] val0, val1;
    logic             valid0, valid1, busy0, busy1;

    int passed = 0;
    int total  = 0;

    int unsigned m_lfsr;
    int          m_prev [2];
    bit          m_have [2];

    int unsigned h_start [$];
    integer      h_val   [$];
    int          h_cnt   [$];
    bit          h_ok    [$];

    range_lfsr_rng #(.WIDTH(WIDTH), .LFSR_WIDTH(LW), .SEED(32'h0000_ACE1), .MAX_TRIES(MT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_max(max_in),
        .i_seed_load(seed_load), .i_seed(seed),
        .o_value(val0), .o_valid(valid0), .o_busy(busy0)
    );

    range_lfsr_rng #(.WIDTH(WIDTH), .LFSR_WIDTH(LW), .SEED(32'h0000_ACE1), .MAX_TRIES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_max(max_in),
        .i_seed_load(seed_load), .i_seed(seed),
        .o_value(val1), .o_valid(valid1), .o_busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned step(input int unsigned s);
        return (s & 1) ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Reference LFSR state, tracked from the bench's own inputs.
    always @(posedge clk) begin
        if (!rst_n)         m_lfsr = SEED;
        else if (seed_load) m_lfsr = (seed == 0) ? SEED : int'(seed);
        else                m_lfsr = step(m_lfsr);
    end

    function automatic logic sel_valid(input int which);
        return (which != 0) ? valid1 : valid0;
    endfunction
    function automatic logic [WIDTH-1:0] sel_val(input int which);
        return (which != 0) ? val1 : val0;
    endfunction
    function automatic logic sel_busy(input int which);
        return (which != 0) ? busy1 : busy0;
    endfunction

    // Draw outcome from the rules: candidates are successive LFSR states cut to the
    // smallest power-of-two range covering mx, retried until in range or tries run out.
    task automatic predict(input int which, input int unsigned start, input int mx,
                           output int val, output int lat);
        int          mt = (which != 0) ? 1 : MT;
        int          m  = 1;
        int unsigned s  = start;
        int          cand, r;
        bit          rule;
        while (m <= mx) m = m * 2;
        rule = NOREP && m_have[which] && (mx > 0);
        val = -1;
        lat = 0;
        for (int t = 0; t < mt; t++) begin
            cand = int'(s % 16) % m;
            if (cand <= mx && !(rule && cand == m_prev[which])) begin
                val = cand;
                lat = t + 1;
                break;
            end
            if (t == mt - 1) begin
                r = (cand > mx) ? cand - (mx + 1) : cand;
                if (rule && r == m_prev[which]) r = (r + 1) % (mx + 1);
                val = r;
                lat = mt;
            end
            s = step(s);
        end
        m_prev[which] = val;
        m_have[which] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0; seed_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_prev = '{0, 0};
        m_have = '{1'b0, 1'b0};
    endtask

    task automatic load_seed(input int unsigned s);
        @(negedge clk);
        seed_load = 1'b1; seed = LW'(s);
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input int which, input int limit, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            if (sel_valid(which) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic draw(input int which, input int mx, input int gap, output int unsigned start,
                        output integer got, output int n, output bit ok, output logic busy_acc);
        repeat (gap + 1) @(negedge clk);
        req = 1'b1; max_in = WIDTH'(mx);
        start = step(m_lfsr);
        @(negedge clk);
        busy_acc = sel_busy(which);
        req = 1'b0; max_in = WIDTH'($urandom);
        wait_valid(which, 20, n, ok);
        got = sel_val(which);
    endtask

    task automatic run_held(input int which, input int mx, input int draws);
        int c; bit ok;
        h_start.delete(); h_val.delete(); h_cnt.delete(); h_ok.delete();
        @(negedge clk);
        req = 1'b1; max_in = WIDTH'(mx);
        for (int k = 0; k < draws; k++) begin
            h_start.push_back(step(m_lfsr));
            wait_valid(which, 20, c, ok);
            h_val.push_back(sel_val(which));
            h_cnt.push_back(c);
            h_ok.push_back(ok);
            if (!ok) break;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (val0 !== 4'd0)  $display("FAIL reset_value got=%0h exp=0", val0); else passed++;
        total++; if (valid0 !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid0); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy0); else passed++;
        total++; if (val1 !== 4'd0)  $display("FAIL reset_value1 got=%0h exp=0", val1); else passed++;
    endtask

    task automatic test_max_zero();
        int unsigned st; integer got; int n, ev, el; bit ok; logic b;
        draw(0, 0, $urandom_range(3), st, got, n, ok, b);
        predict(0, st, 0, ev, el);
        total++; if (!ok) $display("FAIL max0_timeout got=none exp=valid"); else passed++;
        total++; if (n !== 1) $display("FAIL max0_latency got=%0d exp=1", n); else passed++;
        total++; if (got !== 0) $display("FAIL max0_value got=%0h exp=0", got); else passed++;
        total++; if (b !== 1'b1) $display("FAIL max0_busy_draw got=%0b exp=1", b); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL max0_busy_done got=%0b exp=0", busy0); else passed++;
        repeat (3) @(negedge clk);
        total++; if (valid0 !== 1'b0 || val0 !== 4'd0)
            $display("FAIL max0_hold got=%0b/%0h exp=0/0", valid0, val0); else passed++;
    endtask

    task automatic test_range_back_to_back();
        int ev, el, worst_gap; bit [15:0] seen;
        do_reset();
        load_seed($urandom_range(1, 16'hFFFF));
        run_held(0, 12, 2000);
        seen = '0; worst_gap = 0;
        total++; if (h_val.size() != 2000) $display("FAIL b2b_count got=%0d exp=2000", h_val.size()); else passed++;
        for (int i = 0; i < h_val.size(); i++) begin
            predict(0, h_start[i], 12, ev, el);
            total++;
            if (!h_ok[i] || h_val[i] !== ev || h_cnt[i] != el + 1 || h_val[i] > 12)
                $display("FAIL b2b_draw%0d got=%0d/%0d cyc exp=%0d/%0d cyc", i, h_val[i], h_cnt[i], ev, el + 1);
            else passed++;
            if (h_ok[i] && h_val[i] <= 15) seen[h_val[i]] = 1'b1;
            if (h_cnt[i] - 1 > worst_gap) worst_gap = h_cnt[i] - 1;
        end
        total++; if (seen !== 16'h1FFF) $display("FAIL b2b_coverage got=%04h exp=1fff", seen); else passed++;
        total++; if (worst_gap > MT) $display("FAIL b2b_gap got=%0d exp<=%0d", worst_gap, MT); else passed++;
    endtask

    task automatic test_seed();
        int mx [16]; int gp [16]; integer res [4][16];
        int unsigned seeds [4] = '{32'h1234, 32'h1234, 0, 32'hACE1};
        int unsigned st; integer got; int n, ev, el; bit ok; logic b;
        for (int i = 0; i < 16; i++) begin mx[i] = $urandom_range(15); gp[i] = $urandom_range(3); end
        for (int r = 0; r < 4; r++) begin
            do_reset();
            load_seed(seeds[r]);
            for (int i = 0; i < 16; i++) begin
                draw(0, mx[i], gp[i], st, got, n, ok, b);
                predict(0, st, mx[i], ev, el);
                res[r][i] = got;
                total++;
                if (!ok || got !== ev || n != el)
                    $display("FAIL seed_run%0d_draw%0d got=%0d/%0d exp=%0d/%0d", r, i, got, n, ev, el);
                else passed++;
            end
        end
        for (int i = 0; i < 16; i++) begin
            total++; if (res[0][i] !== res[1][i])
                $display("FAIL seed_repeat%0d got=%0d exp=%0d", i, res[1][i], res[0][i]); else passed++;
            total++; if (res[2][i] !== res[3][i])
                $display("FAIL seed_zero%0d got=%0d exp=%0d", i, res[2][i], res[3][i]); else passed++;
        end
    endtask

    task automatic test_max_tries_one();
        int unsigned st; integer got; int n, ev, el; bit ok; logic b;
        do_reset();
        load_seed($urandom_range(1, 16'hFFFF));
        for (int i = 0; i < 40; i++) begin
            draw(1, 8, $urandom_range(2), st, got, n, ok, b);
            predict(1, st, 8, ev, el);
            total++;
            if (!ok || n != 1 || got !== ev || got > 8)
                $display("FAIL tries1_draw%0d got=%0d/%0d exp=%0d/1", i, got, n, ev);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_draw();
        int unsigned st; integer got; int n, ev, el, seen_valid; bit ok; logic b;
        do_reset();
        load_seed($urandom_range(1, 16'hFFFF));
        @(negedge clk);
        req = 1'b1; max_in = 4'hF;
        @(negedge clk);
        req = 1'b0;
        total++; if (busy0 !== 1'b1) $display("FAIL midrst_busy_before got=%0b exp=1", busy0); else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (valid0 !== 1'b0 || val0 !== 4'd0 || busy0 !== 1'b0)
            $display("FAIL midrst_state got=%0b/%0h/%0b exp=0/0/0", valid0, val0, busy0); else passed++;
        rst_n = 1'b1;
        m_prev = '{0, 0};
        m_have = '{1'b0, 1'b0};
        seen_valid = 0;
        repeat (10) begin @(negedge clk); if (valid0 !== 1'b0) seen_valid++; end
        total++; if (seen_valid != 0) $display("FAIL midrst_no_valid got=%0d exp=0", seen_valid); else passed++;
        draw(0, 9, 0, st, got, n, ok, b);
        predict(0, st, 9, ev, el);
        total++; if (!ok || got !== ev || n != el)
            $display("FAIL midrst_after got=%0d/%0d exp=%0d/%0d", got, n, ev, el); else passed++;
    endtask

    task automatic test_repeat();
        int ev, el, reps;
        do_reset();
        load_seed($urandom_range(1, 16'hFFFF));
        run_held(0, 1, 500);
        reps = 0;
        total++; if (h_val.size() != 500) $display("FAIL rep_count got=%0d exp=500", h_val.size()); else passed++;
        for (int i = 0; i < h_val.size(); i++) begin
            predict(0, h_start[i], 1, ev, el);
            total++;
            if (!h_ok[i] || h_val[i] !== ev || h_cnt[i] != el + 1)
                $display("FAIL rep_draw%0d got=%0d/%0d exp=%0d/%0d", i, h_val[i], h_cnt[i], ev, el + 1);
            else passed++;
            if (i > 0 && h_val[i] === h_val[i-1]) reps++;
        end
`ifdef RNG_NO_REPEAT_EN
        total++; if (reps != 0) $display("FAIL rep_alternate got=%0d repeats exp=0", reps); else passed++;
`else
        total++; if (reps == 0) $display("FAIL rep_present got=0 repeats exp>0"); else passed++;
`endif
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; max_in = '0; seed_load = 1'b0; seed = '0;
        m_lfsr = SEED;
        m_prev = '{0, 0};
        m_have = '{1'b0, 1'b0};
        test_reset();
        test_max_zero();
        test_range_back_to_back();
        test_seed();
        test_max_tries_one();
        test_reset_mid_draw();
        test_repeat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/range_lfsr_rng.md
Name: range_lfsr_rng

Overview:
- Parametrised successor to the counter-based random value source used by the card/dealer logic.
- Replaces "free-running counter sampled every clock" with a seedable Galois LFSR, a request/valid handshake, and range-limited output in [0, i_max] via bounded rejection sampling.
- Sits between game-control FSM (requester) and deck/card-draw logic (consumer).

Parameters:
- WIDTH, 4: output value width, 1..16.
- LFSR_WIDTH, 16: LFSR state width; supported values 8, 16, 24, 32 only; must be >= WIDTH.
- SEED, 16'hACE1: reset/substitute seed, zero-extended/truncated to LFSR_WIDTH; must be nonzero.
- MAX_TRIES, 8: rejected candidates allowed before fallback, >= 1.

Ports:
- i_clk  in  1  system clock; all logic on posedge.
- i_rst_n  in  1  synchronous active-low reset, sampled on posedge i_clk.
- i_request  in  1  level; sampled in IDLE only; starts one draw.
- i_max  in  WIDTH  inclusive upper bound; latched at request acceptance.
- i_seed_load  in  1  load i_seed into LFSR this edge.
- i_seed  in  LFSR_WIDTH  seed value; 0 is replaced by SEED.
- o_value  out  WIDTH  last delivered value; held between draws.
- o_valid  out  1  one-cycle pulse; o_value new in the same cycle.
- o_busy  out  1  high while in DRAW.

Behaviour:
- Reset (i_rst_n=0 at edge): lfsr<=SEED, state<=IDLE, o_value<=0, o_valid<=0, o_busy<=0, max_q<=0, tries<=0. Reset mid-DRAW aborts; no o_valid is produced.
- LFSR: Galois, right-shift, maximal-length taps (8: x^8+x^6+x^5+x^4+1; 16: x^16+x^14+x^13+x^11+1; 24: x^24+x^23+x^22+x^17+1; 32: x^32+x^22+x^2+x+1). Advances every non-reset clock regardless of state, so request timing adds entropy.
- Seed load: i_seed_load has priority over the advance: lfsr<=(i_seed==0 ? SEED : i_seed). Allowed in any state; an in-progress draw continues from the new state.
- Mask: all ones from bit 0 up to the MSB of max_q; max_q=0 gives mask=0.
- Candidate: cand = lfsr[WIDTH-1:0] & mask, using the current (pre-advance) lfsr.
- FSM states: IDLE, DRAW.
  - IDLE: o_busy=0. i_request=1 at edge: max_q<=i_max, tries<=0, state goes to DRAW.
  - DRAW: o_busy=1. Every edge, evaluate cand.
  - Accept (cand<=max_q): o_value<=cand, o_valid<=1, state goes to IDLE.
  - Reject with tries<MAX_TRIES-1: tries++, stay in DRAW.
  - Reject with tries==MAX_TRIES-1 (fallback): o_value<=cand-(max_q+1), which is always in range since cand<=mask<2*(max_q+1); o_valid<=1; state goes to IDLE.
- o_valid is high for exactly one cycle per accepted request.
- Latency: request sampled at edge k; o_valid high after edge k+1 minimum; after edge k+MAX_TRIES maximum.
- i_request while in DRAW is ignored (not queued). Changes to i_max during DRAW are ignored.
- Request high in the o_valid cycle (state already IDLE): accepted at that edge, giving back-to-back draws. A held-high i_request yields continuous draws.
- i_max=0: always accepts 0 on the first try.
- i_max = all ones: mask = all ones, never rejects.

Optional Feature:
- Macro: RNG_NO_REPEAT_EN.
- Defined:
  - Candidates equal to the previously delivered o_value are also rejected, as long as max_q>0 and at least one value has been delivered since reset.
  - The fallback path applies the same rule: if the fallback result equals the previous value, deliver (result+1) wrapped modulo (max_q+1).
  - max_q=0 still delivers 0.
- Undefined: no repeat filtering; repeats are allowed.

Test Plan:
- Reset, then i_max=0, pulse i_request -> o_valid exactly 2 edges after request, o_value=0, o_busy high for 1 cycle.
- i_max=12, 2000 back-to-back draws (i_request held) -> every o_value<=12; all 13 values observed; no o_valid gap longer than MAX_TRIES cycles.
- i_seed_load with i_seed=16'h1234, then 16 draws at identical cycle offsets; repeat -> identical 16-value sequences. i_seed=0 -> sequence matches seed 16'hACE1.
- MAX_TRIES=1, i_max=8 -> all values <=8; every o_valid exactly 2 edges after request (fallback path hit, checked against reference model).
- i_rst_n low during DRAW -> no o_valid; o_value=0, o_busy=0 next cycle; new request after release completes normally.
- RNG_NO_REPEAT_EN defined, i_max=1, 500 draws -> strictly alternating 0/1 after first value; undefined -> at least one repeat observed.
